axi_ldb_s: RTL

AXI read-channel forwarder: accepts one read burst at a time on an upstream AXI AR/R slave interface and forwards it to a downstream AXI AR/R master interface, normally `axi_mem_model`. It returns read data upstream through a 2-entry R buffer. It is the read-direction companion of the write forwarder on the same link. It also enforces burst length, generating `s_rlast` locally and flagging downstream `rlast` mismatches. Timeout protection returns it to idle.

---
 rtl/axi_ldb_s.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_ldb_s.sv
// AXI read-channel forwarder: one burst at a time, 2-entry R buffer,
// local rlast generation with downstream rlast checking and stall timeout.
module axi_ldb_s #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int TIMEOUT    = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_arvalid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    output logic                  s_arready,
    output logic                  s_rvalid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    input  logic                  s_rready,
    output logic                  m_arvalid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    output logic                  m_rready,
    output logic                  err_timeout,
    output logic                  err_rlast
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FWD_AR = 2'd1,
        ST_FWD_R  = 2'd2
    } state_e;

    localparam logic [6:0] TIMEOUT_C = 7'(TIMEOUT);

    state_e                state_q, state_d;
    logic                  s_arready_q, s_arready_d;
    logic                  m_arvalid_q, m_arvalid_d;
    logic [ADDR_WIDTH-1:0] m_araddr_q, m_araddr_d;
    logic [7:0]            m_arlen_q, m_arlen_d;
    logic [2:0]            m_arsize_q, m_arsize_d;
    logic [1:0]            m_arburst_q, m_arburst_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [6:0]            wait_cnt_q, wait_cnt_d;
    logic                  term_q, term_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [0:1];
    logic [DATA_WIDTH-1:0] fifo_data_d [0:1];
    logic [1:0]            fifo_resp_q [0:1];
    logic [1:0]            fifo_resp_d [0:1];
    logic                  fifo_last_q [0:1];
    logic                  fifo_last_d [0:1];
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_rlast_q, err_rlast_d;

    logic ar_hs_s;
    logic m_rready_s;
    logic push_s;
    logic pop_s;
    logic exp_last_s;
    logic mism_s;
    logic head_last_s;
    logic r_idle_s;

    // m_rready depends only on registered state so no input reaches it combinationally.
    assign m_rready_s  = (state_q == ST_FWD_R) && (cnt_q < 2'd2) && !term_q;
    assign ar_hs_s     = s_arvalid && s_arready_q;
    assign push_s      = m_rvalid && m_rready_s;
    assign pop_s       = (cnt_q != 2'd0) && s_rready;
    assign exp_last_s  = (beat_cnt_q == m_arlen_q);
    assign mism_s      = (m_rlast != exp_last_s);
    assign head_last_s = fifo_last_q[rd_ptr_q];
    assign r_idle_s    = (cnt_q == 2'd0) && !m_rvalid && !term_q;

    // Next-state, capture, FIFO and error-pulse logic.
    always_comb begin
        state_d       = state_q;
        s_arready_d   = s_arready_q;
        m_arvalid_d   = m_arvalid_q;
        m_araddr_d    = m_araddr_q;
        m_arlen_d     = m_arlen_q;
        m_arsize_d    = m_arsize_q;
        m_arburst_d   = m_arburst_q;
        beat_cnt_d    = beat_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        term_d        = term_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_data_d   = fifo_data_q;
        fifo_resp_d   = fifo_resp_q;
        fifo_last_d   = fifo_last_q;
        err_timeout_d = 1'b0;
        err_rlast_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    m_araddr_d  = s_araddr;
                    m_arlen_d   = s_arlen;
                    m_arsize_d  = s_arsize;
                    m_arburst_d = s_arburst;
                    m_arvalid_d = 1'b1;
                    s_arready_d = 1'b0;
                    beat_cnt_d  = 8'd0;
                    wait_cnt_d  = 7'd0;
                    state_d     = ST_FWD_AR;
                end else begin
                    s_arready_d = 1'b1;
                end
            end
            ST_FWD_AR: begin
                if (m_arready) begin
                    m_arvalid_d = 1'b0;
                    state_d     = ST_FWD_R;
                end else if (wait_cnt_q >= TIMEOUT_C) begin
                    m_arvalid_d   = 1'b0;
                    err_timeout_d = 1'b1;
                    s_arready_d   = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 7'd1;
                end
            end
            ST_FWD_R: begin
                if (push_s) begin
                    fifo_data_d[wr_ptr_q] = m_rdata;
                    fifo_resp_d[wr_ptr_q] = mism_s ? 2'b10 : m_rresp;
                    fifo_last_d[wr_ptr_q] = exp_last_s || m_rlast;
                    wr_ptr_d   = ~wr_ptr_q;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    err_rlast_d = mism_s;
                    if (exp_last_s || m_rlast) begin
                        term_d = 1'b1;
                    end else begin
                        term_d = term_q;
                    end
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                if (pop_s) begin
                    rd_ptr_d = ~rd_ptr_q;
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                cnt_d = cnt_q + {1'b0, push_s} - {1'b0, pop_s};

                // The last beat is always the tail, so popping it empties the buffer.
                if (pop_s && head_last_s) begin
                    term_d      = 1'b0;
                    cnt_d       = 2'd0;
                    s_arready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (r_idle_s) begin
                    if (wait_cnt_q >= TIMEOUT_C) begin
                        cnt_d         = 2'd0;
                        rd_ptr_d      = wr_ptr_q;
                        err_timeout_d = 1'b1;
                        s_arready_d   = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 7'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            s_arready_q    <= 1'b0;
            m_arvalid_q    <= 1'b0;
            m_araddr_q     <= '0;
            m_arlen_q      <= 8'd0;
            m_arsize_q     <= 3'd0;
            m_arburst_q    <= 2'd0;
            beat_cnt_q     <= 8'd0;
            wait_cnt_q     <= 7'd0;
            term_q         <= 1'b0;
            cnt_q          <= 2'd0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_resp_q[0] <= 2'd0;
            fifo_resp_q[1] <= 2'd0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_rlast_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_arready_q   <= s_arready_d;
            m_arvalid_q   <= m_arvalid_d;
            m_araddr_q    <= m_araddr_d;
            m_arlen_q     <= m_arlen_d;
            m_arsize_q    <= m_arsize_d;
            m_arburst_q   <= m_arburst_d;
            beat_cnt_q    <= beat_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            term_q        <= term_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_data_q   <= fifo_data_d;
            fifo_resp_q   <= fifo_resp_d;
            fifo_last_q   <= fifo_last_d;
            err_timeout_q <= err_timeout_d;
            err_rlast_q   <= err_rlast_d;
        end
    end

    assign s_arready   = s_arready_q;
    assign s_rvalid    = (cnt_q != 2'd0);
    assign s_rdata     = fifo_data_q[rd_ptr_q];
    assign s_rresp     = fifo_resp_q[rd_ptr_q];
    assign s_rlast     = fifo_last_q[rd_ptr_q];
    assign m_arvalid   = m_arvalid_q;
    assign m_araddr    = m_araddr_q;
    assign m_arlen     = m_arlen_q;
    assign m_arsize    = m_arsize_q;
    assign m_arburst   = m_arburst_q;
    assign m_rready    = m_rready_s;
    assign err_timeout = err_timeout_q;
    assign err_rlast   = err_rlast_q;

endmodule
